// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control unit:
// opcode/funct encodings, FSM state codes, ALU operation codes and the
// ALU_SrcB / PC_Src mux selections. The +4 step constant chosen by
// SRCB_STEP lives in the datapath. This block only selects it.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_SLLV = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_STEP    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEMADDR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB      = 4'd7,
        S_BR      = 4'd8,
        S_J       = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_MEM,
        CLS_BR,
        CLS_J,
        CLS_ILL
    } instr_class_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control-unit <-> datapath bundle.
//   master : control unit (drives register-file addresses, write enables,
//            ALU/PC/memory controls; receives Inst and Zero)
//   slave  : datapath / instruction memory side
interface mips_multicycle_ctrl_if;
    logic [31:0] Inst;
    logic        Zero;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [4:0]  W_Addr;
    logic        Write_Reg;
    logic        Mem_to_Reg;
    logic [2:0]  ALU_OP;
    logic        ALU_SrcA;
    logic [1:0]  ALU_SrcB;
    logic [31:0] Imm_Ext;
    logic        PC_Write;
    logic [1:0]  PC_Src;
    logic        IR_Write;
    logic        Mem_Write;
    logic [3:0]  State;
    logic        Illegal;

    modport master (
        input  Inst, Zero,
        output R_Addr_A, R_Addr_B, W_Addr, Write_Reg, Mem_to_Reg, ALU_OP,
               ALU_SrcA, ALU_SrcB, Imm_Ext, PC_Write, PC_Src, IR_Write,
               Mem_Write, State, Illegal
    );

    modport slave (
        output Inst, Zero,
        input  R_Addr_A, R_Addr_B, W_Addr, Write_Reg, Mem_to_Reg, ALU_OP,
               ALU_SrcA, ALU_SrcB, Imm_Ext, PC_Write, PC_Src, IR_Write,
               Mem_Write, State, Illegal
    );
endinterface

// File: rtl/mips_multicycle_ctrl_decoder.sv
// Purely combinational instruction decoder.
//   op, funct : IR[31:26], IR[5:0]
//   cls       : instruction class steering the S_ID branch
//   alu_op    : ALU operation for the execute step (funct map for R-type,
//               opcode map for I-ALU, add otherwise)
//   zero_ext  : immediate is zero-extended (andi/ori/xori)
//   is_lw     : load, selects memory write-back
//   illegal   : opcode/funct outside the supported subset
module mips_instr_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output alu_op_t      alu_op,
    output logic         zero_ext,
    output logic         is_lw,
    output logic         illegal
);

    always_comb begin
        cls      = CLS_ILL;
        alu_op   = ALU_ADD;
        zero_ext = 1'b0;
        is_lw    = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls = CLS_R;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLLV: alu_op = ALU_SLLV;
                    default: cls    = CLS_ILL;
                endcase
            end
            OP_ADDI: begin cls = CLS_I; alu_op = ALU_ADD; end
            OP_SLTI: begin cls = CLS_I; alu_op = ALU_SLT; end
            OP_ANDI: begin cls = CLS_I; alu_op = ALU_AND; zero_ext = 1'b1; end
            OP_ORI:  begin cls = CLS_I; alu_op = ALU_OR;  zero_ext = 1'b1; end
            OP_XORI: begin cls = CLS_I; alu_op = ALU_XOR; zero_ext = 1'b1; end
            OP_LW:   begin cls = CLS_MEM; is_lw = 1'b1; end
            OP_SW:   cls = CLS_MEM;
            OP_BEQ,
            OP_BNE:  cls = CLS_BR;
            OP_J:    cls = CLS_J;
            default: cls = CLS_ILL;
        endcase
    end

    assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU. Latches the instruction
// in S_IF, decodes it and sequences ALU, PC, memory and register-file
// controls. Write_Reg spans the whole WB cycle so the register file's
// negedge write lands mid-cycle.
//   CLK, RST : clock (posedge), asynchronous active-low reset
//   bus      : master side of mips_multicycle_ctrl_if
//
// state      | meaning
// S_IF    0  | fetch: IR<=Inst, PC<=PC+4
// S_ID    1  | decode, branch target into ALUOut
// S_EXE_R 2  | R-type execute
// S_EXE_I 3  | I-ALU execute
// S_MEMADDR 4| lw/sw address computation
// S_MEM_RD 5 | data-memory read
// S_MEM_WR 6 | data-memory write
// S_WB    7  | register-file write-back
// S_BR    8  | beq/bne compare, conditional PC load
// S_J     9  | jump
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    mips_multicycle_ctrl_if.master bus
);

    state_t       state, state_nxt;
    logic [31:0]  ir;
    logic         illegal_q, set_illegal;

    instr_class_t cls;
    alu_op_t      dec_alu_op;
    logic         zero_ext, is_lw, dec_illegal, is_bne;

    logic         ir_write, pc_write, write_reg, mem_write, mem_to_reg, alu_src_a;
    logic [2:0]   alu_op;
    logic [1:0]   alu_src_b, pc_src;

    mips_instr_decoder u_dec (
        .op       (ir[31:26]),
        .funct    (ir[5:0]),
        .cls      (cls),
        .alu_op   (dec_alu_op),
        .zero_ext (zero_ext),
        .is_lw    (is_lw),
        .illegal  (dec_illegal)
    );

    assign is_bne = (ir[31:26] == OP_BNE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IF;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IF) ir <= bus.Inst;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = S_IF;
        set_illegal = 1'b0;
        case (state)
            S_IF: state_nxt = S_ID;
            S_ID: begin
                set_illegal = dec_illegal;
                case (cls)
                    CLS_R:   state_nxt = S_EXE_R;
                    CLS_I:   state_nxt = S_EXE_I;
                    CLS_MEM: state_nxt = S_MEMADDR;
                    CLS_BR:  state_nxt = S_BR;
                    CLS_J:   state_nxt = S_J;
                    default: state_nxt = S_IF;
                endcase
            end
            S_EXE_R,
            S_EXE_I,
            S_MEM_RD:  state_nxt = S_WB;
            S_MEMADDR: state_nxt = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_WR,
            S_WB,
            S_BR,
            S_J:       state_nxt = S_IF;
            default: begin
                // Codes 10-15 are unreachable in normal operation.
                state_nxt   = S_IF;
                set_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        write_reg  = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_op     = ALU_AND;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        case (state)
            S_IF: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_STEP;
                alu_op    = ALU_ADD;
            end
            S_ID: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_op    = ALU_ADD;
            end
            S_EXE_R: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
            end
            S_EXE_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_alu_op;
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_WR: mem_write = 1'b1;
            S_WB: begin
                write_reg  = 1'b1;
                mem_to_reg = is_lw;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                // Only Mealy output: the branch resolves in this same cycle.
                pc_write  = is_bne ? ~bus.Zero : bus.Zero;
            end
            S_J: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
        // Asynchronous reset must silence every write strobe immediately,
        // including IR_Write/PC_Write that S_IF would otherwise assert.
        if (!RST) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            write_reg = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign bus.R_Addr_A   = ir[25:21];
    assign bus.R_Addr_B   = ir[20:16];
    assign bus.W_Addr     = (ir[31:26] == OP_RTYPE) ? ir[15:11] : ir[20:16];
    assign bus.Imm_Ext    = zero_ext ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
    assign bus.Write_Reg  = write_reg;
    assign bus.Mem_to_Reg = mem_to_reg;
    assign bus.ALU_OP     = alu_op;
    assign bus.ALU_SrcA   = alu_src_a;
    assign bus.ALU_SrcB   = alu_src_b;
    assign bus.PC_Write   = pc_write;
    assign bus.PC_Src     = pc_src;
    assign bus.IR_Write   = ir_write;
    assign bus.Mem_Write  = mem_write;
    assign bus.State      = state;
    assign bus.Illegal    = illegal_q;

endmodule
